// File: rtl/mem_pkg.sv
// Shared types and defaults for the wait-state memory responder.
//   state_t     : responder FSM states (IDLE, WAIT, RESP)
//   op_t        : captured access kind (OP_READ, OP_WRITE)
//   addr_legal  : word-aligned and inside the memory window
package mem_pkg;

  localparam int unsigned DATA_W              = 32;
  localparam int unsigned CNT_W               = 4;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Legal when the two low bits are zero and nothing sits above the word index.
  function automatic logic addr_legal(input logic [DATA_W-1:0] addr,
                                      input int unsigned       addr_bits);
    logic [DATA_W-1:0] hi;
    hi = addr >> (addr_bits + 2);
    return (addr[1:0] == 2'b00) && (hi == '0);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word memory, synchronous write and synchronous read.
//   clk, reset : clock; reset clears only the read register, never the storage
//   en, we     : access strobe and direction (we=1 write, we=0 read)
//   idx        : word index
//   wdata      : write data
//   rdata      : read register, holds its value until the next read
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  localparam int unsigned ADDR_BITS  = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Storage has no reset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register updates only on a read access.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder for a multi-cycle CPU's unified memory.
//   clk, reset          : clock, synchronous active-high reset
//   mem_read, mem_write : request strobes, sampled only while idle
//   addr, wdata         : byte address and store data, captured with the request
//   rdata               : last read word (registered)
//   ready               : one-cycle completion pulse
//   busy                : high while a request is in flight
//   err                 : one-cycle pulse for a rejected request
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned ADDR_BITS = $clog2(DEPTH_WORDS);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  op_t                    op_q, op_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   err_c;
  logic                   mem_en_c;
  logic                   mem_we_c;
  logic                   legal_c;

  assign legal_c = addr_legal(addr, ADDR_BITS);

  // State, counter and captured request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      idx_q   <= '0;
      wdata_q <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ready   <= (state_d == ST_RESP);
      busy    <= (state_d != ST_IDLE);
      err     <= err_c;
    end
  end

  // Next-state, capture and access strobe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    err_c    = 1'b0;
    mem_en_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          if ((mem_read && mem_write) || !legal_c) begin
            err_c = 1'b1;
          end else begin
            op_d    = mem_write ? OP_WRITE : OP_READ;
            idx_d   = addr[ADDR_BITS+1:2];
            wdata_d = wdata;
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mem_en_c = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_we_c = (op_q == OP_WRITE);

  // Reset on the access edge must abort the pending write.
  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem_array (
    .clk   (clk),
    .reset (reset),
    .en    (mem_en_c && !reset),
    .we    (mem_we_c),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        mem_read2 = 1'b0, mem_write2 = 1'b0;
  logic [31:0] addr2 = '0, wdata2 = '0;
  logic [31:0] rdata2;
  logic        ready2, busy2, err2;

  logic        mem_read0 = 1'b0, mem_write0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [31:0] rdata0;
  logic        ready0, busy0, err0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(256)) u_dut2 (
    .clk(clk), .reset(reset), .mem_read(mem_read2), .mem_write(mem_write2),
    .addr(addr2), .wdata(wdata2), .rdata(rdata2), .ready(ready2), .busy(busy2), .err(err2)
  );

  mem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(256)) u_dut0 (
    .clk(clk), .reset(reset), .mem_read(mem_read0), .mem_write(mem_write0),
    .addr(addr0), .wdata(wdata0), .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge, then withdraw it.
  task automatic drive_req(input bit u0, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
    if (u0) begin
      mem_read0 = r; mem_write0 = w; addr0 = a; wdata0 = d;
    end else begin
      mem_read2 = r; mem_write2 = w; addr2 = a; wdata2 = d;
    end
    step();
    mem_read0 = 1'b0; mem_write0 = 1'b0;
    mem_read2 = 1'b0; mem_write2 = 1'b0;
  endtask

  // Edges from acceptance until ready is seen (bounded; 40 means timeout).
  task automatic wait_ready(input bit u0, output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (u0 ? ready0 : ready2) return;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    vectors++; if (rdata2 !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got=%h want=00000000", rdata2); end
    vectors++; if (ready2 !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b want=0", ready2); end
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy2); end
    vectors++; if (err2 !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b want=0", err2); end
    vectors++; if ({rdata0, ready0, busy0, err0} !== 35'h0) begin miscompares++; $display("FAIL reset_dut0 got=%h/%b%b%b want=0", rdata0, ready0, busy0, err0); end
  endtask

  task automatic test_write();
    int lat;
    drive_req(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    vectors++; if (busy2 !== 1'b1) begin miscompares++; $display("FAIL wr_busy got=%b want=1", busy2); end
    vectors++; if (ready2 !== 1'b0) begin miscompares++; $display("FAIL wr_ready_early got=%b want=0", ready2); end
    wait_ready(1'b0, lat);
    vectors++; if (lat != 3) begin miscompares++; $display("FAIL wr_latency got=%0d want=3", lat); end
    vectors++; if (err2 !== 1'b0) begin miscompares++; $display("FAIL wr_err got=%b want=0", err2); end
    vectors++; if (busy2 !== 1'b1) begin miscompares++; $display("FAIL wr_busy_resp got=%b want=1", busy2); end
    step();
    vectors++; if ({ready2, busy2} !== 2'b00) begin miscompares++; $display("FAIL wr_done got=%b%b want=00", ready2, busy2); end
  endtask

  task automatic test_read();
    int lat;
    drive_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    wait_ready(1'b0, lat);
    vectors++; if (lat != 3) begin miscompares++; $display("FAIL rd_latency got=%0d want=3", lat); end
    vectors++; if (rdata2 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data got=%h want=deadbeef", rdata2); end
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++; if (rdata2 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_hold[%0d] got=%h want=deadbeef", i, rdata2); end
    end
    vectors++; if ({ready2, busy2} !== 2'b00) begin miscompares++; $display("FAIL rd_idle got=%b%b want=00", ready2, busy2); end
  endtask

  task automatic test_errors();
    logic [31:0] bad [4];
    bad[0] = 32'h12; bad[1] = 32'h400; bad[2] = 32'h13; bad[3] = 32'h8000_0010;
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b0, 1'b1, 1'b0, bad[i], 32'h0);
      vectors++; if (err2 !== 1'b1) begin miscompares++; $display("FAIL err_pulse[%h] got=%b want=1", bad[i], err2); end
      vectors++; if ({busy2, ready2} !== 2'b00) begin miscompares++; $display("FAIL err_busy[%h] got=%b%b want=00", bad[i], busy2, ready2); end
      vectors++; if (rdata2 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL err_rdata[%h] got=%h want=deadbeef", bad[i], rdata2); end
      step();
      vectors++; if (err2 !== 1'b0) begin miscompares++; $display("FAIL err_once[%h] got=%b want=0", bad[i], err2); end
    end
    // Misaligned write must not touch memory either.
    drive_req(1'b0, 1'b0, 1'b1, 32'h11, 32'h0BAD0BAD);
    vectors++; if ({err2, busy2} !== 2'b10) begin miscompares++; $display("FAIL err_wr got=%b%b want=10", err2, busy2); end
    step();
  endtask

  task automatic test_both_and_busy();
    int lat;
    int pulses;
    drive_req(1'b0, 1'b1, 1'b1, 32'h10, 32'h0);
    vectors++; if ({err2, busy2} !== 2'b10) begin miscompares++; $display("FAIL both_err got=%b%b want=10", err2, busy2); end
    step();
    vectors++; if (err2 !== 1'b0) begin miscompares++; $display("FAIL both_once got=%b want=0", err2); end
    // Write 0x14, then hammer requests while busy.
    drive_req(1'b0, 1'b0, 1'b1, 32'h14, 32'h11111111);
    pulses = 0;
    mem_write2 = 1'b1; addr2 = 32'h14; wdata2 = 32'h22222222;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ready2) pulses++;
      mem_read2 = (i == 1);
    end
    mem_write2 = 1'b0; mem_read2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ready2) pulses++;
    end
    vectors++; if (pulses != 1) begin miscompares++; $display("FAIL busy_pulses got=%0d want=1", pulses); end
    drive_req(1'b0, 1'b1, 1'b0, 32'h14, 32'h0);
    wait_ready(1'b0, lat);
    vectors++; if (rdata2 !== 32'h11111111) begin miscompares++; $display("FAIL busy_ignored got=%h want=11111111", rdata2); end
    step();
    drive_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    wait_ready(1'b0, lat);
    vectors++; if (rdata2 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL both_noaccess got=%h want=deadbeef", rdata2); end
    step();
  endtask

  task automatic test_read_after_write();
    int lat;
    drive_req(1'b0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D);
    wait_ready(1'b0, lat);
    step();
    drive_req(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
    wait_ready(1'b0, lat);
    vectors++; if (rdata2 !== 32'hCAFEF00D) begin miscompares++; $display("FAIL raw_data got=%h want=cafef00d", rdata2); end
    step();
  endtask

  task automatic test_reset_abort();
    int lat;
    drive_req(1'b0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5);
    wait_ready(1'b0, lat);
    step();
    drive_req(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678);
    step();
    reset = 1'b1;
    step();
    vectors++; if ({rdata2, ready2, busy2, err2} !== 35'h0) begin miscompares++; $display("FAIL abort_outputs got=%h/%b%b%b want=0", rdata2, ready2, busy2, err2); end
    step();
    // Reset wins over a simultaneous request.
    mem_read2 = 1'b1; addr2 = 32'h20;
    step();
    mem_read2 = 1'b0;
    reset = 1'b0;
    vectors++; if ({busy2, err2} !== 2'b00) begin miscompares++; $display("FAIL reset_priority got=%b%b want=00", busy2, err2); end
    step();
    drive_req(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    wait_ready(1'b0, lat);
    vectors++; if (rdata2 !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL abort_mem got=%h want=a5a5a5a5", rdata2); end
    step();
    drive_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    wait_ready(1'b0, lat);
    vectors++; if (rdata2 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL reset_keeps_mem got=%h want=deadbeef", rdata2); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    drive_req(1'b1, 1'b0, 1'b1, 32'h0, 32'h00000013);
    wait_ready(1'b1, lat);
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL w0_latency got=%0d want=1", lat); end
    step();
    drive_req(1'b1, 1'b0, 1'b1, 32'h4, 32'h00500093);
    wait_ready(1'b1, lat);
    step();
    drive_req(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    vectors++; if ({busy0, ready0} !== 2'b10) begin miscompares++; $display("FAIL b2b_accept got=%b%b want=10", busy0, ready0); end
    wait_ready(1'b1, lat);
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL b2b_lat0 got=%0d want=1", lat); end
    vectors++; if (rdata0 !== 32'h00000013) begin miscompares++; $display("FAIL b2b_data0 got=%h want=00000013", rdata0); end
    step();
    drive_req(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
    wait_ready(1'b1, lat);
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL b2b_lat1 got=%0d want=1", lat); end
    vectors++; if (rdata0 !== 32'h00500093) begin miscompares++; $display("FAIL b2b_data1 got=%h want=00500093", rdata0); end
    vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL b2b_err got=%b want=0", err0); end
    step();
    vectors++; if ({ready0, busy0} !== 2'b00) begin miscompares++; $display("FAIL b2b_idle got=%b%b want=00", ready0, busy0); end
  endtask

  initial begin
    step();
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_both_and_busy();
    test_read_after_write();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
